// File: rtl/johnson_seq_pkg.sv
// johnson_seq_pkg: sequencer FSM states and step-direction encodings
// shared by johnson_seq_ctrl and johnson_core.
package johnson_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic DIR_FWD = 1'b0;
   localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/johnson_core.sv
// johnson_core: WIDTH-bit Johnson register, one shift per step_en,
// direction chosen by dir (DIR_FWD / DIR_REV).
module johnson_core
   import johnson_seq_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             Clock,
   input  logic             Reset_n,
   input  logic             step_en,
   input  logic             dir,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         count <= '0;
      end else if (step_en) begin
         if (dir == DIR_REV)
            count <= {~count[0], count[WIDTH-1:1]};
         else
            count <= {count[WIDTH-2:0], ~count[WIDTH-1]};
      end
   end

endmodule

// File: rtl/johnson_seq_ctrl.sv
// johnson_seq_ctrl: runs a Johnson counter for a requested number of steps
// at a divided rate; reverse stepping only with JOHNSON_SEQ_REVERSE_EN.
module johnson_seq_ctrl
   import johnson_seq_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8,
   parameter int DIV_W = 8
) (
   input  logic             Clock,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic [CNT_W-1:0] Steps,
   input  logic [DIV_W-1:0] Div,
   input  logic             Dir,
   input  logic             Hold,
   input  logic             Abort,
   output logic [WIDTH-1:0] Count_out,
   output logic             Busy,
   output logic             Done,
   output logic             Step_strobe,
   output logic [CNT_W-1:0] Steps_left
);

   state_t           state, state_d;
   logic [DIV_W-1:0] presc, presc_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] left_d;
   logic             dir_q, dir_d;
   logic             dir_start;
   logic             step;

`ifdef JOHNSON_SEQ_REVERSE_EN
   assign dir_start = Dir;
`else
   logic unused_dir;
   assign unused_dir = Dir;
   assign dir_start  = DIR_FWD;
`endif

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state       <= ST_IDLE;
         presc       <= '0;
         div_q       <= '0;
         dir_q       <= DIR_FWD;
         Steps_left  <= '0;
         Busy        <= 1'b0;
         Done        <= 1'b0;
         Step_strobe <= 1'b0;
      end else begin
         state       <= state_d;
         presc       <= presc_d;
         div_q       <= div_d;
         dir_q       <= dir_d;
         Steps_left  <= left_d;
         Busy        <= (state_d == ST_RUN);
         Done        <= (state == ST_DONE);
         Step_strobe <= step;
      end
   end

   always_comb begin
      state_d = state;
      presc_d = presc;
      div_d   = div_q;
      dir_d   = dir_q;
      left_d  = Steps_left;
      step    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (Start && !Abort) begin
               div_d   = Div;
               dir_d   = dir_start;
               presc_d = '0;
               left_d  = Steps;
               state_d = (Steps == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            // Abort wins over a step landing on the same edge
            if (Abort) begin
               state_d = ST_IDLE;
            end else if (!Hold) begin
               if (presc == div_q) begin
                  step    = 1'b1;
                  presc_d = '0;
                  left_d  = Steps_left - CNT_W'(1);
                  if (Steps_left == CNT_W'(1))
                     state_d = ST_DONE;
               end else begin
                  presc_d = presc + DIV_W'(1);
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   johnson_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .Clock  (Clock),
      .Reset_n(Reset_n),
      .step_en(step),
      .dir    (dir_q),
      .count  (Count_out)
   );

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// tb_johnson_seq_ctrl: directed and random runs of johnson_seq_ctrl
// against a step-index reference model.
module tb_johnson_seq_ctrl;

   localparam int W  = 4;
   localparam int CW = 8;
   localparam int DW = 8;

`ifdef JOHNSON_SEQ_REVERSE_EN
   localparam bit REV_EN = 1'b1;
`else
   localparam bit REV_EN = 1'b0;
`endif

   logic          Clock = 1'b0;
   logic          Reset_n = 1'b1;
   logic          Start = 1'b0;
   logic [CW-1:0] Steps = '0;
   logic [DW-1:0] Div = '0;
   logic          Dir = 1'b0;
   logic          Hold = 1'b0;
   logic          Abort = 1'b0;
   logic [W-1:0]  Count_out;
   logic          Busy;
   logic          Done;
   logic          Step_strobe;
   logic [CW-1:0] Steps_left;

   int total = 0;
   int bad   = 0;

   // reference model: position in the 2W-long Johnson cycle
   int m_idx, m_left, m_div, m_act;
   bit m_dir, m_run, m_fin;
   bit exp_busy, exp_done, exp_strobe;

   johnson_seq_ctrl #(
      .WIDTH(W), .CNT_W(CW), .DIV_W(DW)
   ) dut (
      .Clock      (Clock),
      .Reset_n    (Reset_n),
      .Start      (Start),
      .Steps      (Steps),
      .Div        (Div),
      .Dir        (Dir),
      .Hold       (Hold),
      .Abort      (Abort),
      .Count_out  (Count_out),
      .Busy       (Busy),
      .Done       (Done),
      .Step_strobe(Step_strobe),
      .Steps_left (Steps_left)
   );

   always #5 Clock = ~Clock;

   function automatic logic [W-1:0] pat(int idx);
      logic [W-1:0] ones;
      ones = '1;
      if (idx < W) return W'((1 << idx) - 1);
      return W'(ones << (idx - W));
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_idx = 0; m_left = 0; m_div = 0; m_act = 0;
      m_dir = 0; m_run = 0; m_fin = 0;
      exp_busy = 0; exp_done = 0; exp_strobe = 0;
   endtask

   task automatic model_edge();
      exp_done   = 0;
      exp_strobe = 0;
      if (!Reset_n) begin
         model_reset();
      end else if (m_fin) begin
         m_fin    = 0;
         exp_done = 1;
      end else if (m_run) begin
         if (Abort) begin
            m_run = 0;
         end else if (!Hold) begin
            m_act++;
            if (m_act % (m_div + 1) == 0) begin
               m_idx = m_dir ? (m_idx + 2*W - 1) % (2*W) : (m_idx + 1) % (2*W);
               exp_strobe = 1;
               m_left--;
               if (m_left == 0) begin
                  m_run = 0;
                  m_fin = 1;
               end
            end
         end
      end else if (Start && !Abort) begin
         m_left = int'(Steps);
         m_div  = int'(Div);
         m_dir  = REV_EN ? Dir : 1'b0;
         m_act  = 0;
         if (m_left == 0) m_fin = 1;
         else m_run = 1;
      end
      exp_busy = m_run;
   endtask

   task automatic check_all(string tag);
      chk({tag, ".count"}, 32'(Count_out), 32'(pat(m_idx)));
      chk({tag, ".left"}, 32'(Steps_left), 32'(m_left));
      chk({tag, ".busy"}, 32'(Busy), 32'(exp_busy));
      chk({tag, ".done"}, 32'(Done), 32'(exp_done));
      chk({tag, ".strobe"}, 32'(Step_strobe), 32'(exp_strobe));
   endtask

   task automatic tick(string tag);
      model_edge();
      @(posedge Clock);
      #1;
      check_all(tag);
   endtask

   task automatic run_start(int s, int d, bit dr);
      Steps = CW'(s);
      Div   = DW'(d);
      Dir   = dr;
      Start = 1'b1;
      tick("start");
      Start = 1'b0;
   endtask

   initial begin
      model_reset();
      #2 Reset_n = 1'b0;
      #1 check_all("reset");
      tick("reset_hold");
      Reset_n = 1'b1;

      // eight forward steps at full rate wrap back to 0000
      run_start(8, 0, 0);
      repeat (10) tick("fwd8");
      chk("fwd8.wrap", 32'(Count_out), 32'(4'b0000));

      // two reverse steps from 0000 (forward when reverse disabled)
      run_start(2, 0, 1);
      repeat (4) tick("dir");
      chk("dir.end", 32'(Count_out), REV_EN ? 32'(4'b1100) : 32'(4'b0011));

      // divided rate: one step every third cycle
      run_start(3, 2, 0);
      repeat (11) tick("div2");

      // abort on the edge of the second step
      run_start(4, 0, 0);
      tick("abort_s1");
      Abort = 1'b1;
      tick("abort");
      Abort = 1'b0;
      chk("abort.left", 32'(Steps_left), 32'd3);
      repeat (3) tick("abort_after");

      // hold stretches step spacing, Busy stays high
      run_start(2, 1, 0);
      tick("hold_pre");
      Hold = 1'b1;
      repeat (5) tick("hold");
      Hold = 1'b0;
      repeat (5) tick("hold_post");

      // zero-step request completes without stepping
      run_start(0, 3, 0);
      repeat (3) tick("zero");

      // Start with Abort in idle is ignored; Start mid-run is ignored
      Start = 1'b1; Abort = 1'b1; Steps = 8'd5;
      tick("start_abort");
      Start = 1'b0; Abort = 1'b0;
      run_start(3, 1, 0);
      Start = 1'b1; Steps = 8'd7;
      repeat (3) tick("restart");
      Start = 1'b0;
      repeat (6) tick("restart_end");

      // random traffic
      for (int i = 0; i < 400; i++) begin
         Start = ($urandom_range(0, 3) == 0);
         Steps = CW'($urandom_range(0, 5));
         Div   = DW'($urandom_range(0, 3));
         Dir   = 1'($urandom_range(0, 1));
         Hold  = ($urandom_range(0, 3) == 0);
         Abort = ($urandom_range(0, 15) == 0);
         tick("rand");
      end
      Start = 1'b0; Hold = 1'b0; Abort = 1'b0;

      // reset in the middle of a run clears outputs at once
      run_start(6, 0, 0);
      repeat (2) tick("pre_rst");
      #3 Reset_n = 1'b0;
      model_reset();
      #1 check_all("async_rst");
      tick("rst_low");
      Reset_n = 1'b1;
      repeat (2) tick("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/johnson_seq_ctrl.md
JOHNSON_SEQ_CTRL -- requirements
Module: johnson_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of Johnson stages (valid range 2..16).
REQ-002 SHALL have parameter CNT_W, default 8, width of the step-count request.
REQ-003 SHALL have parameter DIV_W, default 8, width of the step-rate divider.
REQ-004 SHALL have port Clock  input  1  sole clock, rising edge.
REQ-005 SHALL have port Reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port Start  input  1  run request, sampled in IDLE only.
REQ-007 SHALL have port Steps  input  CNT_W  number of steps to run, latched on Start.
REQ-008 SHALL have port Div  input  DIV_W  one step per Div+1 clocks, latched on Start.
REQ-009 SHALL have port Dir  input  1  0 = forward, 1 = reverse, latched on Start.
REQ-010 SHALL have port Hold  input  1  freezes the prescaler while high.
REQ-011 SHALL have port Abort  input  1  terminates the run.
REQ-012 SHALL have port Count_out  output  WIDTH  Johnson pattern.
REQ-013 SHALL have port Busy  output  1  high in RUN.
REQ-014 SHALL have port Done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port Step_strobe  output  1  high in the cycle Count_out changes.
REQ-016 SHALL have port Steps_left  output  CNT_W  remaining steps.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE; all outputs registered.
REQ-018 IDLE: Start=1 with Steps>0 SHALL latch Steps/Div/Dir, clear prescaler, enter RUN next edge; Steps=0 SHALL go directly to DONE.
REQ-019 RUN: prescaler SHALL count 0..Div; when at Div and Hold=0, step occurs, prescaler wraps to 0; first step lands Div+1 cycles after the Start edge.
REQ-020 Forward step SHALL be Count_out <= {Count_out[WIDTH-2:0], ~Count_out[WIDTH-1]}; reverse SHALL be {~Count_out[0], Count_out[WIDTH-1:1]}.
REQ-021 Each step SHALL decrement Steps_left and assert Step_strobe for exactly that cycle.
REQ-022 The step taking Steps_left to 0 SHALL move FSM to DONE; DONE SHALL assert Done for one cycle, then return to IDLE.
REQ-023 Hold=1 SHALL freeze the prescaler and suppress steps; Busy SHALL stay high.
REQ-024 Abort=1 in RUN SHALL return to IDLE next edge with no Done pulse, no further step, Count_out and Steps_left retained; Abort has priority over a coincident step.
REQ-025 Start outside IDLE SHALL be ignored; Start and Abort both high in IDLE SHALL be ignored.
REQ-026 Count_out SHALL persist across runs; a new run continues from the current pattern.
REQ-027 Count_out SHALL only ever hold the 2*WIDTH legal Johnson codes.

Reset
REQ-028 Reset_n=0 SHALL asynchronously force IDLE, Count_out=0, Steps_left=0, prescaler=0, Busy=0, Done=0, Step_strobe=0.
REQ-029 Reset mid-run SHALL abandon the run with no Done pulse; the first edge after release is in IDLE.

Configuration
REQ-030 Macro JOHNSON_SEQ_REVERSE_EN defined SHALL enable reverse stepping per Dir.
REQ-031 Without JOHNSON_SEQ_REVERSE_EN, Dir SHALL be ignored and all steps SHALL be forward; the port remains.

Structure
REQ-032 Package johnson_seq_pkg SHALL hold the FSM state enum and the forward/reverse direction constants.
REQ-033 Sub-module johnson_core SHALL hold the WIDTH-bit register with step-enable and direction inputs; the FSM and prescaler stay in johnson_seq_ctrl.

Verification
REQ-034 Reset, then Start, Steps=8, Div=0, Dir=0 -> Count_out 0001,0011,0111,1111,1110,1100,1000,0000 on consecutive cycles; Done one cycle after the 8th step.
REQ-035 Steps=3, Div=2 -> Step_strobe every 3rd cycle, first at Start+3; Steps_left 2,1,0.
REQ-036 From 0000, Dir=1, Steps=2, Div=0 (macro on) -> 1000, 1100; macro off -> 0001, 0011.
REQ-037 Steps=4, Div=0, Abort in the cycle of the 2nd step -> Count_out 0001, IDLE, Steps_left=3, no Done.
REQ-038 Steps=2, Div=1, Hold high 5 cycles mid-run -> step spacing stretched by 5 cycles, Busy constant high.
REQ-039 Steps=0 -> Done next cycle, no Step_strobe; Reset_n low mid-run -> all outputs 0 immediately.
